j_prefetch: RTL and testbench

- Instruction prefetch queue for the Jerry DSP, directly upstream of the execution controller.
- Fetches 32-bit longwords from local memory and buffers them as 16-bit instruction words.
- Presents the head word with insrdy; the execution controller pops it with romold.
- Flushes and refetches on a program-counter load (jump or GPU write to PC).

---
 rtl/j_prefetch.sv | 129 ++++++++++++
 tb/tb_j_prefetch.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/j_prefetch.sv
// Jerry DSP instruction prefetch queue: fetches longwords and presents 16-bit words to the execution controller.
// Optional macro JPF_BYPASS_EN: an empty queue presents the first pushed word combinationally in the mack cycle.
//
// state | meaning
// IDLE  | no fetch outstanding; starts one when go=1 and two words are free
// REQ   | mreq held at maddr until mack (or until a pcld abandons it)
module j_prefetch #(
  parameter int QDEPTH = 4,
  parameter int AW     = 24
) (
  input  logic          clk_0,
  input  logic          reset,
  input  logic          go,
  input  logic          pcld,
  input  logic [AW-1:0] pcdata,
  input  logic          romold,
  output logic          insrdy,
  output logic [15:0]   instr,
  output logic [AW-1:0] pc,
  output logic          mreq,
  output logic [AW-1:0] maddr,
  input  logic          mack,
  input  logic [31:0]   mdata
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] FILL_MAX = (PW+1)'(QDEPTH - 2);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t        state_q, state_d;
  // Word-granular addresses: bit 0 of every byte address is always zero.
  logic [AW-1:1] fptr_q, fptr_d;
  logic [AW-1:1] pc_q, pc_d;
  logic [PW-1:0] rdptr_q, rdptr_d;
  logic [PW-1:0] wrptr_q, wrptr_d;
  logic [PW:0]   count_q, count_d;
  logic [15:0]   buf_q [QDEPTH];
  logic [15:0]   buf_d [QDEPTH];

  logic          push, pop, pop_reg, byp, two;
  logic [15:0]   w0, w1;
  logic [PW:0]   nwr;
  logic          unused_pcdata0;

  assign unused_pcdata0 = pcdata[0];

  always_comb begin
    push = (state_q == REQ) && mack && !pcld;
    two  = !fptr_q[1];
    w0   = two ? mdata[31:16] : mdata[15:0];
    w1   = mdata[15:0];
`ifdef JPF_BYPASS_EN
    byp  = push && (count_q == '0);
`else
    byp  = 1'b0;
`endif
    pop     = romold && !pcld && ((count_q != '0) || byp);
    pop_reg = pop && !byp;

    state_d = state_q;
    fptr_d  = fptr_q;
    pc_d    = pc_q;
    rdptr_d = rdptr_q;
    wrptr_d = wrptr_q;
    count_d = count_q;
    buf_d   = buf_q;
    nwr     = '0;

    case (state_q)
      IDLE:    if (go && (count_q <= FILL_MAX)) state_d = REQ;
      REQ:     if (mack) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (pcld) begin
      state_d = IDLE;
      count_d = '0;
      rdptr_d = '0;
      wrptr_d = '0;
      pc_d    = pcdata[AW-1:1];
      fptr_d  = pcdata[AW-1:1];
    end else begin
      if (push) begin
        fptr_d = fptr_q + (two ? (AW-1)'(2) : (AW-1)'(1));
        // A bypassed word consumed in the mack cycle never enters the buffer.
        if (byp && pop) begin
          if (two) buf_d[wrptr_q] = w1;
          nwr = two ? (PW+1)'(1) : '0;
        end else begin
          buf_d[wrptr_q] = w0;
          if (two) buf_d[wrptr_q + PW'(1)] = w1;
          nwr = two ? (PW+1)'(2) : (PW+1)'(1);
        end
      end
      if (pop) pc_d = pc_q + (AW-1)'(1);
      wrptr_d = wrptr_q + nwr[PW-1:0];
      rdptr_d = rdptr_q + PW'(pop_reg);
      count_d = count_q + nwr - (PW+1)'(pop_reg);
    end
  end

  always_ff @(posedge clk_0 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      fptr_q  <= '0;
      pc_q    <= '0;
      rdptr_q <= '0;
      wrptr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < QDEPTH; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      fptr_q  <= fptr_d;
      pc_q    <= pc_d;
      rdptr_q <= rdptr_d;
      wrptr_q <= wrptr_d;
      count_q <= count_d;
      buf_q   <= buf_d;
    end
  end

  assign insrdy = (count_q != '0) || byp;
  assign instr  = byp ? w0 : buf_q[rdptr_q];
  assign pc     = {pc_q, 1'b0};
  assign mreq   = (state_q == REQ);
  assign maddr  = {fptr_q[AW-1:2], 2'b00};

endmodule

// File: tb/tb_j_prefetch.sv
// Directed bench for j_prefetch (QDEPTH=4, AW=24); bypass checks compile only with JPF_BYPASS_EN.
module tb_j_prefetch;

  logic        clk_0, reset, go, pcld, romold, mack;
  logic [23:0] pcdata;
  logic [31:0] mdata;
  logic        insrdy, mreq;
  logic [15:0] instr;
  logic [23:0] pc, maddr;

  int n_cmp = 0;
  int n_err = 0;

  j_prefetch #(.QDEPTH(4), .AW(24)) dut (
    .clk_0(clk_0), .reset(reset), .go(go), .pcld(pcld), .pcdata(pcdata),
    .romold(romold), .insrdy(insrdy), .instr(instr), .pc(pc),
    .mreq(mreq), .maddr(maddr), .mack(mack), .mdata(mdata)
  );

  initial clk_0 = 1'b0;
  always #5 clk_0 = ~clk_0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_0);
    #1;
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; pcld = 1'b0; romold = 1'b0; mack = 1'b0;
    pcdata = '0; mdata = '0;
    #2;
    chk("rst_insrdy", 32'(insrdy), 32'h0);
    chk("rst_instr",  32'(instr),  32'h0);
    chk("rst_pc",     32'(pc),     32'h0);
    chk("rst_mreq",   32'(mreq),   32'h0);
    chk("rst_maddr",  32'(maddr),  32'h0);
    cyc();
    reset = 1'b0;

    // aligned fetch and pop
    pcld = 1'b1; pcdata = 24'hF03000; go = 1'b1;
    cyc();
    pcld = 1'b0;
    chk("t1_mreq_idle", 32'(mreq), 32'h0);
    cyc();
    chk("t1_mreq",  32'(mreq),  32'h1);
    chk("t1_maddr", 32'(maddr), 32'hF03000);
    mack = 1'b1; mdata = 32'h98001234;
    cyc();
    mack = 1'b0;
    chk("t1_insrdy", 32'(insrdy), 32'h1);
    chk("t1_instr0", 32'(instr),  32'h9800);
    chk("t1_pc0",    32'(pc),     32'hF03000);
    chk("t1_mreq_after", 32'(mreq), 32'h0);
    romold = 1'b1;
    cyc();
    romold = 1'b0;
    chk("t1_instr1", 32'(instr), 32'h1234);
    chk("t1_pc1",    32'(pc),    32'hF03002);
    chk("t1_maddr2", 32'(maddr), 32'hF03004);
    chk("t1_mreq2",  32'(mreq),  32'h1);

    // misaligned jump abandoning a pending request
    pcld = 1'b1; pcdata = 24'hF03002;
    cyc();
    pcld = 1'b0;
    chk("t2_insrdy_flush", 32'(insrdy), 32'h0);
    chk("t2_pc_flush",     32'(pc),     32'hF03002);
    cyc();
    chk("t2_maddr", 32'(maddr), 32'hF03000);
    mack = 1'b1; mdata = 32'hAAAABBBB;
    cyc();
    mack = 1'b0;
    chk("t2_instr", 32'(instr), 32'hBBBB);
    chk("t2_pc",    32'(pc),    32'hF03002);
    cyc();
    chk("t2_mreq_next",  32'(mreq),  32'h1);
    chk("t2_maddr_next", 32'(maddr), 32'hF03004);
    romold = 1'b1;
    cyc();
    romold = 1'b0;
    chk("t2_single_word", 32'(insrdy), 32'h0);

    // fill and backpressure
    mack = 1'b1; mdata = 32'h11112222;
    cyc();
    mack = 1'b0;
    chk("t3_mreq_a", 32'(mreq), 32'h0);
    cyc();
    chk("t3_maddr2", 32'(maddr), 32'hF03008);
    mack = 1'b1; mdata = 32'h33334444;
    cyc();
    mack = 1'b0;
    chk("t3_head_full", 32'(instr), 32'h1111);
    cyc();
    chk("t3_full_nreq", 32'(mreq), 32'h0);
    romold = 1'b1;
    cyc();
    romold = 1'b0;
    chk("t3_instr_pop1", 32'(instr), 32'h2222);
    cyc();
    chk("t3_pop1_nreq", 32'(mreq), 32'h0);
    romold = 1'b1;
    cyc();
    romold = 1'b0;
    chk("t3_instr_pop2", 32'(instr), 32'h3333);
    chk("t3_pop2_nreq", 32'(mreq), 32'h0);
    cyc();
    chk("t3_req_resume", 32'(mreq),  32'h1);
    chk("t3_req_maddr",  32'(maddr), 32'hF0300C);

    // push+pop to count 3, then pcld with mack and romold
    romold = 1'b1; mack = 1'b1; mdata = 32'h55556666;
    cyc();
    romold = 1'b0; mack = 1'b0;
    chk("t4_instr_c3", 32'(instr), 32'h4444);
    pcld = 1'b1; pcdata = 24'h123457; mack = 1'b1; mdata = 32'h77778888; romold = 1'b1;
    cyc();
    pcld = 1'b0; mack = 1'b0; romold = 1'b0;
    chk("t4_insrdy", 32'(insrdy), 32'h0);
    chk("t4_pc",     32'(pc),     32'h123456);
    cyc();
    chk("t4_mreq",  32'(mreq),  32'h1);
    chk("t4_maddr", 32'(maddr), 32'h123454);
    pcld = 1'b1; pcdata = 24'h200000; mack = 1'b1; mdata = 32'hDEADBEEF;
    cyc();
    pcld = 1'b0; mack = 1'b0;
    chk("t4_drop_insrdy", 32'(insrdy), 32'h0);
    chk("t4_drop_mreq",   32'(mreq),   32'h0);
    cyc();
    mack = 1'b1; mdata = 32'h9999AAAA;
    cyc();
    mack = 1'b0;
    chk("t4_new_instr", 32'(instr), 32'h9999);
    chk("t4_new_pc",    32'(pc),    32'h200000);

    // address wrap
    pcld = 1'b1; pcdata = 24'hFFFFFC;
    cyc();
    pcld = 1'b0;
    cyc();
    chk("t5_maddr_top", 32'(maddr), 32'hFFFFFC);
    mack = 1'b1; mdata = 32'hBEEF0123;
    cyc();
    mack = 1'b0;
    chk("t5_maddr_wrap", 32'(maddr), 32'h000000);
    chk("t5_instr",      32'(instr), 32'hBEEF);
    romold = 1'b1;
    cyc();
    chk("t5_pc_mid",  32'(pc),    32'hFFFFFE);
    chk("t5_instr2",  32'(instr), 32'h0123);
    cyc();
    chk("t5_pc_wrap",   32'(pc),     32'h000000);
    chk("t5_empty",     32'(insrdy), 32'h0);
    cyc();
    romold = 1'b0;
    chk("t5_pop_empty_ignored", 32'(pc), 32'h000000);

    // go drop during REQ
    go = 1'b0;
    cyc();
    chk("t6_hold_a", 32'(mreq), 32'h1);
    cyc();
    chk("t6_hold_b", 32'(mreq), 32'h1);
    mack = 1'b1; mdata = 32'hCAFED00D;
    cyc();
    mack = 1'b0;
    chk("t6_mreq_off", 32'(mreq),  32'h0);
    chk("t6_instr",    32'(instr), 32'hCAFE);
    cyc();
    chk("t6_no_new_req", 32'(mreq), 32'h0);

`ifdef JPF_BYPASS_EN
    pcld = 1'b1; pcdata = 24'h000100; go = 1'b1;
    cyc();
    pcld = 1'b0;
    cyc();
    chk("byp_maddr", 32'(maddr), 32'h000100);
    mack = 1'b1; romold = 1'b1; mdata = 32'h13572468;
    #1;
    chk("byp_insrdy", 32'(insrdy), 32'h1);
    chk("byp_instr",  32'(instr),  32'h1357);
    chk("byp_pc",     32'(pc),     32'h000100);
    cyc();
    mack = 1'b0; romold = 1'b0;
    chk("byp_rest_instr", 32'(instr), 32'h2468);
    chk("byp_rest_pc",    32'(pc),    32'h000102);
    romold = 1'b1;
    cyc();
    romold = 1'b0;
    chk("byp_count1", 32'(insrdy), 32'h0);
`endif

    // async reset mid-request
    pcld = 1'b1; pcdata = 24'h000200; go = 1'b1;
    cyc();
    pcld = 1'b0;
    cyc();
    chk("rst2_req", 32'(mreq), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst2_mreq",  32'(mreq),  32'h0);
    chk("rst2_pc",    32'(pc),    32'h0);
    chk("rst2_maddr", 32'(maddr), 32'h0);
    cyc();
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
